// File: rtl/fifo_demux_defs.sv
// fifo_demux_defs: shared state encoding and default sizes for the FIFO pop demux
package fifo_demux_defs;
    localparam int DATA_W_DEF  = 6;
    localparam int SEL_LSB_DEF = 4;
    localparam int CNT_W_DEF   = 8;
    localparam int NUM_DEST    = 4;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;
endpackage

// File: rtl/fifo_demux_stats.sv
// fifo_demux_stats: wrapping delivered-word counter and saturating stall counter
module fifo_demux_stats
    import fifo_demux_defs::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             word_inc,
    input  logic             stall_inc,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] stall_cnt
);
    // word count wraps; stall count sticks at all-ones
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            word_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (word_inc) word_cnt <= word_cnt + 1'b1;
            if (stall_inc && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/fifo_demux_pop.sv
// fifo_demux_pop: pops the upstream FIFO and routes each word to one of four destinations by class; FIFO_DEMUX_STATS_EN enables the statistics counters
module fifo_demux_pop
    import fifo_demux_defs::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SEL_LSB = SEL_LSB_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                enable2,
    input  logic                fifo_empty,
    input  logic [DATA_W-1:0]   fifo_data_out,
    input  logic                fifo_error,
    input  logic [NUM_DEST-1:0] dest_almost_full,
    output logic                fifo_pop,
    output logic [NUM_DEST-1:0] dest_push,
    output logic [DATA_W-1:0]   dest_data,
    output logic                busy,
    output logic                err_sticky,
    output logic [CNT_W-1:0]    word_cnt,
    output logic [CNT_W-1:0]    stall_cnt
);
    state_t            state;
    logic [DATA_W-1:0] hold_q;
    logic [1:0]        sel;
    logic              push_ok;
    logic              push;
    logic              pop;

    assign sel     = hold_q[SEL_LSB+1:SEL_LSB];
    assign push_ok = !dest_almost_full[sel];
    assign push    = (state == ST_SEND) && push_ok;
    // a new pop is only allowed when no word is held, or the held word leaves this cycle
    assign pop     = enable2 && !fifo_empty && ((state == ST_IDLE) || push);

    // strobes are gated by reset so nothing leaks out while reset_L is low
    always_comb begin
        fifo_pop  = reset_L && pop;
        dest_push = (reset_L && push) ? NUM_DEST'(1) << sel : '0;
    end

    assign dest_data = hold_q;
    assign busy      = (state != ST_IDLE);

    // single-word pipeline: IDLE pops, LOAD captures the read data, SEND waits for room
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state  <= ST_IDLE;
            hold_q <= '0;
        end else begin
            case (state)
                ST_IDLE: if (pop) state <= ST_LOAD;
                ST_LOAD: begin
                    hold_q <= fifo_data_out;
                    state  <= ST_SEND;
                end
                ST_SEND: if (push) state <= pop ? ST_LOAD : ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // upstream error is latched for software and never blocks the datapath
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) err_sticky <= 1'b0;
        else if (fifo_error) err_sticky <= 1'b1;
    end

`ifdef FIFO_DEMUX_STATS_EN
    fifo_demux_stats #(.CNT_W(CNT_W)) u_stats (
        .clk       (clk),
        .reset_L   (reset_L),
        .word_inc  (push),
        .stall_inc ((state == ST_SEND) && !push_ok),
        .word_cnt  (word_cnt),
        .stall_cnt (stall_cnt)
    );
`else
    assign word_cnt  = '0;
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_fifo_demux_pop.sv
// tb_fifo_demux_pop: randomized and directed scoreboard bench for fifo_demux_pop
module tb_fifo_demux_pop;
    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       enable2 = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [5:0] fifo_data_out = '0;
    logic       fifo_error = 1'b0;
    logic [3:0] dest_almost_full = '0;
    logic       fifo_pop;
    logic [3:0] dest_push;
    logic [5:0] dest_data;
    logic       busy;
    logic       err_sticky;
    logic [7:0] word_cnt;
    logic [7:0] stall_cnt;

`ifdef FIFO_DEMUX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        int         pc;
        logic [5:0] w;
    } ent_t;

    ent_t       exp_q[$];
    logic [5:0] fq[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         wc = 0;
    int         sc = 0;
    logic       errm = 1'b0;

    always #5 clk = ~clk;

    fifo_demux_pop dut (
        .clk              (clk),
        .reset_L          (reset_L),
        .enable2          (enable2),
        .fifo_empty       (fifo_empty),
        .fifo_data_out    (fifo_data_out),
        .fifo_error       (fifo_error),
        .dest_almost_full (dest_almost_full),
        .fifo_pop         (fifo_pop),
        .dest_push        (dest_push),
        .dest_data        (dest_data),
        .busy             (busy),
        .err_sticky       (err_sticky),
        .word_cnt         (word_cnt),
        .stall_cnt        (stall_cnt)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Reference: a popped word becomes deliverable two cycles after its pop, goes out in
    // order to dest word[5:4] the first cycle that dest has room, and pops happen only
    // when nothing is held or the held word leaves in that same cycle.
    always @(negedge clk) begin : monitor
        logic       has, rdy, pe;
        logic [5:0] w;
        logic [1:0] s;
        cyc = cyc + 1;
        if (!reset_L) begin
            chk("rst_pop", int'(fifo_pop), 0);
            chk("rst_push", int'(dest_push), 0);
            chk("rst_data", int'(dest_data), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_err", int'(err_sticky), 0);
            chk("rst_word_cnt", int'(word_cnt), 0);
            chk("rst_stall_cnt", int'(stall_cnt), 0);
            wc = 0;
            sc = 0;
            errm = 1'b0;
        end else begin
            has = exp_q.size() != 0;
            w = '0;
            rdy = 1'b0;
            if (has) begin
                w = exp_q[0].w;
                rdy = cyc >= exp_q[0].pc + 2;
            end
            s = w[5:4];
            pe = rdy && !dest_almost_full[s];
            chk("busy", int'(busy), int'(has));
            chk("push", int'(dest_push), pe ? (1 << s) : 0);
            if (pe) chk("data", int'(dest_data), int'(w));
            chk("pop", int'(fifo_pop), int'(enable2 && !fifo_empty && (!has || pe)));
            chk("err_sticky", int'(err_sticky), int'(errm));
            chk("word_cnt", int'(word_cnt), STATS ? wc % 256 : 0);
            chk("stall_cnt", int'(stall_cnt), STATS ? sc : 0);
            if (pe) begin
                void'(exp_q.pop_front());
                wc++;
            end else if (rdy && sc < 255) begin
                sc++;
            end
            errm = errm | fifo_error;
        end
    end

    task automatic put(input logic [5:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // one clock: sample the pop decision mid-cycle, serve it from the FIFO model after the edge
    task automatic tick();
        logic p;
        @(negedge clk);
        #1 p = fifo_pop;
        @(posedge clk);
        #1;
        if (p && fq.size() != 0) begin
            fifo_data_out = fq.pop_front();
            exp_q.push_back('{cyc, fifo_data_out});
        end
        fifo_empty = fq.size() == 0;
    endtask

    task automatic do_reset(input int n);
        reset_L = 1'b0;
        fifo_error = 1'b0;
        exp_q.delete();
        repeat (n) tick();
        reset_L = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        enable2 = 1'b1;
        put(6'h25);
        do_reset(3);
        repeat (5) tick();
        put(6'h03); put(6'h17); put(6'h2A); put(6'h3F);
        repeat (10) tick();
        dest_almost_full = 4'b0010;
        put(6'h17);
        repeat (7) tick();
        dest_almost_full = 4'b0000;
        repeat (3) tick();
        put(6'h05); put(6'h0A);
        repeat (2) tick();
        enable2 = 1'b0;
        repeat (3) tick();
        enable2 = 1'b1;
        repeat (6) tick();
        fifo_error = 1'b1;
        tick();
        fifo_error = 1'b0;
        repeat (3) tick();
        put(6'h2A);
        repeat (2) tick();
        do_reset(2);
        repeat (3) tick();
        dest_almost_full = 4'b1000;
        put(6'h3F);
        repeat (270) tick();
        dest_almost_full = 4'b0000;
        repeat (4) tick();
        for (int i = 0; i < 3000; i++) begin
            enable2 = $urandom_range(0, 7) != 0;
            for (int b = 0; b < 4; b++) dest_almost_full[b] = $urandom_range(0, 3) == 0;
            fifo_error = $urandom_range(0, 199) == 0;
            if ($urandom_range(0, 2) != 0 && fq.size() < 8) put(6'($urandom_range(0, 63)));
            if ($urandom_range(0, 799) == 0) do_reset(2);
            else tick();
        end
        enable2 = 1'b1;
        dest_almost_full = 4'b0000;
        fifo_error = 1'b0;
        repeat (30) tick();
        chk("drain_inflight", exp_q.size(), 0);
        chk("drain_fifo", fq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_demux_pop.md
Name: fifo_demux_pop

Overview:
- Downstream consumer of the 6-bit FIFO. Pops words from it and routes each word to one of four destination FIFOs, selected by the class field in the word's top two bits.
- Respects per-destination almost-full backpressure and never drops a popped word.
- Sits between the FIFO's data_out_c/empty_c/error_c outputs and four destination push ports.

Parameters:
- DATA_W, 6, word width; must match the upstream FIFO.
- SEL_LSB, 4, LSB of the 2-bit destination select field, i.e. sel = word[SEL_LSB+1:SEL_LSB].
- CNT_W, 8, width of the statistics counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_L  in  1  asynchronous active-low reset.
- enable2  in  1  global enable; low blocks new pops.
- fifo_empty  in  1  upstream FIFO empty flag (empty_c).
- fifo_data_out  in  DATA_W  upstream FIFO read data; valid the cycle after fifo_pop=1.
- fifo_error  in  1  upstream FIFO error flag (error_c).
- dest_almost_full  in  4  per-destination almost-full; bit i blocks pushes to destination i.
- fifo_pop  out  1  pop strobe to the upstream FIFO.
- dest_push  out  4  one-hot push strobe per destination.
- dest_data  out  DATA_W  data to the destinations (held word).
- busy  out  1  high when state != IDLE.
- err_sticky  out  1  latched upstream error.
- word_cnt  out  CNT_W  words delivered; wraps mod 2^CNT_W.
- stall_cnt  out  CNT_W  SEND cycles blocked by backpressure; saturates at all-ones.

Behaviour:
- Reset (async, reset_L=0): state=IDLE, hold_q=0, dest_data=0, err_sticky=0, word_cnt=0, stall_cnt=0.
  - fifo_pop and dest_push are forced to 0 while reset_L=0, regardless of other inputs.
  - A word held at reset assertion is discarded.
- FSM states: IDLE, LOAD, SEND (2-bit encoding).
- IDLE:
  - fifo_pop = enable2 & ~fifo_empty (combinational).
  - If fifo_pop=1, go to LOAD; else stay in IDLE.
- LOAD:
  - Capture hold_q <= fifo_data_out, then go to SEND. fifo_pop=0.
- SEND: sel = hold_q[SEL_LSB+1:SEL_LSB]; push_ok = ~dest_almost_full[sel].
  - If push_ok:
    - dest_push = 1<<sel for this cycle; word_cnt += 1.
    - fifo_pop = enable2 & ~fifo_empty in the same cycle.
    - Next state is LOAD if that pop fires, else IDLE.
  - If ~push_ok: dest_push=0, fifo_pop=0, stay in SEND; stall_cnt += 1, saturating.
  - enable2 low in SEND does not abort: the held word is still delivered, then the FSM goes to IDLE.
- Latency: a pop in cycle n gives capture in n+1 and the earliest dest_push in n+2.
- Sustained throughput: 1 word per 2 cycles (SEND with concurrent pop, then LOAD, repeating).
- dest_data = hold_q at all times (registered); dest_push is at most one-hot and never asserted outside SEND.
- Simultaneous push_ok and fifo_empty=1: push only, go to IDLE.
- At most one word is in flight; pops are never issued while a word waits in SEND.
- err_sticky is set on any cycle with fifo_error=1 and cleared only by reset. It does not stop the datapath.

Optional Feature:
- Macro: FIFO_DEMUX_STATS_EN.
- Defined: word_cnt and stall_cnt behave as specified above.
- Undefined: counters are not instantiated, and word_cnt and stall_cnt are tied to 0. Ports remain present; all other behaviour is identical.

Decomposition:
- Shared package/include (fifo_demux_defs):
  - state encodings ST_IDLE=2'd0, ST_LOAD=2'd1, ST_SEND=2'd2;
  - defaults DATA_W=6, SEL_LSB=4, CNT_W=8;
  - NUM_DEST=4.
- One sub-module: fifo_demux_stats, containing the wrapping word counter and saturating stall counter.
  - Instantiated only under FIFO_DEMUX_STATS_EN.

Test Plan:
- Reset hold: reset_L=0 with enable2=1, fifo_empty=0 -> fifo_pop=0, dest_push=0, dest_data=0, busy=0. After reset_L rises, fifo_pop=1 in the first IDLE cycle.
- Single word: FIFO presents 6'h25 (sel=2) after pop at cycle n -> dest_push=4'b0100 with dest_data=6'h25 at n+2; word_cnt=1; then IDLE when fifo_empty=1.
- Back-to-back: words 6'h03, 6'h17, 6'h2A, 6'h3F, FIFO never empty -> dest_push = 0001, 0010, 0100, 1000 on every other cycle, each with a coincident fifo_pop (except after the last word if the FIFO is empty); word_cnt=4.
- Backpressure: hold 6'h17 while dest_almost_full=4'b0010 for 5 cycles -> no push, no pop, stall_cnt=5. Push 4'b0010 occurs in the cycle dest_almost_full[1] drops.
- Enable drop: enable2=0 while in SEND with FIFO non-empty -> held word delivered, fifo_pop stays 0, FSM goes to IDLE, busy=0.
- Error/reset: one-cycle fifo_error=1 -> err_sticky=1 until reset. reset_L pulse while in SEND -> word discarded, no dest_push, all outputs back to reset values.
